// File: rtl/rng_ctrl.sv
// Bus-side sequencer for the simplerng core: prefetches random words into a small
// FIFO, serves DATA reads from it, and reseeds the core on SEED writes.
module rng_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_1000,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        rng_enable,
    output logic        rng_we,
    output logic        rng_re,
    output logic [31:0] rng_di,
    input  logic [31:0] rng_do,
    input  logic        rng_wait
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEED
    } state_t;

    function automatic logic [31:0] strobe_mask(input logic [3:0] strb, input logic [31:0] data);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}} & data;
    endfunction

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               en_q, en_d;
    logic [31:0]        seed_q, seed_d;
    logic               pend_q, pend_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;
    logic               stall_q, stall_d;
    logic               seed_wait_q, seed_wait_d;
    logic               ready_q, ready_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        fifo_mem [DEPTH];

    logic               in_win;
    logic               sel;
    logic               is_wr;
    logic [1:0]         reg_idx;
    logic               fetch_acc;
    logic               seed_acc;
    logic               seed_wr;
    logic               data_rd;
    logic               word_ok;
    logic               fifo_empty;
    logic               fifo_full;
    logic               bypass;
    logic               push;
    logic               pop;
    logic [31:0]        status;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^iomem_addr[1:0];

    assign in_win  = (iomem_addr[31:4] == BASE_ADDR[31:4]);
    // A held DATA read or SEED write keeps iomem_valid high; it must not be taken twice.
    assign sel     = iomem_valid && in_win && !ready_q && !stall_q && !seed_wait_q;
    assign is_wr   = |iomem_wstrb;
    assign reg_idx = iomem_addr[3:2];

    assign fetch_acc  = (state_q == ST_FETCH) && !rng_wait;
    assign seed_acc   = (state_q == ST_SEED) && !rng_wait;
    assign seed_wr    = sel && is_wr && (reg_idx == 2'd2);
    assign data_rd    = sel && !is_wr && (reg_idx == 2'd0);
    // A word fetched while a reseed is pending belongs to the old seed and is dropped.
    assign word_ok    = fetch_acc && !pend_q && !seed_wr;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign bypass     = word_ok && (stall_q || (data_rd && fifo_empty && en_q));
    assign push       = word_ok && !bypass;
    assign pop        = data_rd && !fifo_empty;

    assign status = {stall_cnt_q, 5'b0, pend_q, fifo_full, fifo_empty,
                     {(8 - CNT_W){1'b0}}, count_q};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        en_d        = en_q;
        seed_d      = seed_q;
        pend_d      = pend_q;
        stall_cnt_d = stall_cnt_q;
        stall_d     = stall_q;
        seed_wait_d = seed_wait_q;
        ready_d     = 1'b0;
        rdata_d     = 32'h0;

        unique case (state_q)
            ST_IDLE: begin
                if (pend_q || seed_wr) begin
                    state_d = ST_SEED;
                end else if (en_q && !fifo_full) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: if (!rng_wait) state_d = ST_IDLE;
            ST_SEED:  if (!rng_wait) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (seed_acc) begin
            pend_d      = 1'b0;
            seed_wait_d = 1'b0;
            ready_d     = 1'b1;
        end

        if (stall_q && bypass) begin
            stall_d = 1'b0;
            ready_d = 1'b1;
            rdata_d = rng_do;
        end

        if (sel) begin
            unique case (reg_idx)
                2'd0: begin
                    if (is_wr) begin
                        ready_d = 1'b1;
                    end else if (!fifo_empty) begin
                        ready_d = 1'b1;
                        rdata_d = fifo_mem[rd_ptr_q];
                    end else if (en_q) begin
                        if (word_ok) begin
                            ready_d = 1'b1;
                            rdata_d = rng_do;
                        end else begin
                            stall_d = 1'b1;
                            if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
                        end
                    end else begin
                        // Nothing will ever be fetched while disabled, so never hold the bus.
                        ready_d = 1'b1;
                        rdata_d = 32'hFFFF_FFFF;
                    end
                end
                2'd1: begin
                    ready_d = 1'b1;
                    if (is_wr) stall_cnt_d = 16'h0;
                    else       rdata_d     = status;
                end
                2'd2: begin
                    if (is_wr) begin
                        seed_d      = strobe_mask(iomem_wstrb, iomem_wdata);
                        pend_d      = 1'b1;
                        seed_wait_d = 1'b1;
                    end else begin
                        ready_d = 1'b1;
                    end
                end
                2'd3: begin
                    ready_d = 1'b1;
                    if (is_wr) begin
                        if (iomem_wstrb[0]) en_d = iomem_wdata[0];
                    end else begin
                        rdata_d = {31'b0, en_q};
                    end
                end
                default: ;
            endcase
        end

        if (seed_wr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            en_q        <= 1'b1;
            seed_q      <= 32'h0;
            pend_q      <= 1'b0;
            stall_cnt_q <= 16'h0;
            stall_q     <= 1'b0;
            seed_wait_q <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            en_q        <= en_d;
            seed_q      <= seed_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
            seed_wait_q <= seed_wait_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= rng_do;
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign rng_enable  = en_q;
    assign rng_re      = (state_q == ST_FETCH);
    assign rng_we      = (state_q == ST_SEED);
    assign rng_di      = seed_q;

endmodule
